// File: rtl/data_memory_responder_if.sv
// Load/store handshake bundle between a requester and the data memory responder.
// Read and write channels each use a four-phase valid/ready handshake.
interface data_memory_responder_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_addr;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_addr;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;
  logic                 busy;

  modport master (
    output mem_read_valid, mem_read_addr,
    output mem_write_valid, mem_write_addr, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready, busy
  );

  modport slave (
    input  mem_read_valid, mem_read_addr,
    input  mem_write_valid, mem_write_addr, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready, busy
  );
endinterface

// File: rtl/data_memory_responder.sv
// Single-port data memory answering read/write requests after a fixed latency,
// with read priority, abort on early valid drop and a four-phase ready handshake.
module data_memory_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  data_memory_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DONE,
    WRITE_WAIT,
    WRITE_DONE
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [DATA_BITS-1:0] r_rdata;
  logic                 r_rd_ready;
  logic                 r_wr_ready;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic                 w_commit;

  assign w_commit = (r_state == WRITE_WAIT) && (r_cnt == '0) && bus.mem_write_valid;

  // Storage has no reset; gating on reset keeps an in-flight write from landing.
  always_ff @(posedge clk) begin
    if (reset && w_commit) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rd_ready <= 1'b0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mem_read_valid) begin
            r_addr  <= bus.mem_read_addr;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= READ_WAIT;
          end else if (bus.mem_write_valid) begin
            r_addr  <= bus.mem_write_addr;
            r_wdata <= bus.mem_write_data;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= WRITE_WAIT;
          end
        end
        READ_WAIT: begin
          if (!bus.mem_read_valid) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_rdata    <= r_mem[r_addr];
            r_rd_ready <= 1'b1;
            r_state    <= READ_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        READ_DONE: begin
          if (!bus.mem_read_valid) begin
            r_rd_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        WRITE_WAIT: begin
          if (!bus.mem_write_valid) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_wr_ready <= 1'b1;
            r_state    <= WRITE_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRITE_DONE: begin
          if (!bus.mem_write_valid) begin
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_rd_ready <= 1'b0;
          r_wr_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read_ready  = r_rd_ready;
  assign bus.mem_read_data   = r_rdata;
  assign bus.mem_write_ready = r_wr_ready;
  assign bus.busy            = r_busy;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: four instances at latencies 2, 3, 1 and 15,
// directed handshake scenarios followed by random traffic against an array model.
module tb_data_memory_responder;

  logic       clk;
  logic       reset;
  logic [3:0] rv, wv;
  logic [7:0] ra [4];
  logic [7:0] wa [4];
  logic [7:0] wd [4];
  logic [3:0] rr, wr, bz;
  logic [7:0] rdat [4];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] mdl     [4][256];
  bit         known   [4][256];
  logic [7:0] last_rd [4];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : (d == 2) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 15;
    data_memory_responder_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus ();
    assign bus.mem_read_valid  = rv[g];
    assign bus.mem_read_addr   = ra[g];
    assign bus.mem_write_valid = wv[g];
    assign bus.mem_write_addr  = wa[g];
    assign bus.mem_write_data  = wd[g];
    assign rr[g]   = bus.mem_read_ready;
    assign wr[g]   = bus.mem_write_ready;
    assign bz[g]   = bus.busy;
    assign rdat[g] = bus.mem_read_data;
    data_memory_responder #(.ADDR_BITS(8), .DATA_BITS(8), .LATENCY(L)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction; ab>0 drops valid so it is sampled low on the ab-th edge after capture.
  task automatic run_op(input int d, input bit w, input logic [7:0] a,
                        input logic [7:0] v, input int ab);
    int L;
    int hold;
    L = lat(d);
    @(negedge clk);
    if (w) begin wv[d] = 1'b1; wa[d] = a; wd[d] = v; end
    else   begin rv[d] = 1'b1; ra[d] = a; end
    @(posedge clk);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      ra[d] = 8'($urandom); wa[d] = 8'($urandom); wd[d] = 8'($urandom);
      if (k == ab) begin rv[d] = 1'b0; wv[d] = 1'b0; end
      @(posedge clk); #1;
      if (k == ab) begin
        chk("abort_rdy", 32'(w ? wr[d] : rr[d]), 32'd0);
        chk("abort_busy", 32'(bz[d]), 32'd0);
        chk("abort_rdata", 32'(rdat[d]), 32'(last_rd[d]));
        return;
      end
      chk("lat_rdy", 32'(w ? wr[d] : rr[d]), 32'(k == L));
      chk("other_rdy", 32'(w ? rr[d] : wr[d]), 32'd0);
      chk("busy_wait", 32'(bz[d]), 32'd1);
      if (k < L) chk("rdata_hold", 32'(rdat[d]), 32'(last_rd[d]));
    end
    if (w) begin
      mdl[d][a]   = v;
      known[d][a] = 1'b1;
    end else begin
      chk("rd_data", 32'(rdat[d]), 32'(mdl[d][a]));
      last_rd[d] = mdl[d][a];
    end
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("rdy_held", 32'(w ? wr[d] : rr[d]), 32'd1);
      chk("data_held", 32'(rdat[d]), 32'(last_rd[d]));
    end
    @(negedge clk);
    rv[d] = 1'b0; wv[d] = 1'b0;
    @(posedge clk); #1;
    chk("rdy_drop", 32'(w ? wr[d] : rr[d]), 32'd0);
    chk("busy_idle", 32'(bz[d]), 32'd0);
    chk("rdata_keep", 32'(rdat[d]), 32'(last_rd[d]));
  endtask

  initial begin
    logic [7:0] a;
    bit         w;
    int         ab;

    reset = 1'b0;
    rv = '0; wv = '0;
    for (int d = 0; d < 4; d++) begin
      ra[d] = '0; wa[d] = '0; wd[d] = '0; last_rd[d] = '0;
      for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
    end
    #3;
    for (int d = 0; d < 4; d++) begin
      chk("rst_rrdy", 32'(rr[d]), 32'd0);
      chk("rst_wrdy", 32'(wr[d]), 32'd0);
      chk("rst_busy", 32'(bz[d]), 32'd0);
      chk("rst_rdata", 32'(rdat[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Basic write then read-back at latency 2.
    run_op(0, 1'b1, 8'h10, 8'hA5, 0);
    run_op(0, 1'b0, 8'h10, 8'h00, 0);

    // Simultaneous read 0x10 and write 0x20/0x3C: read first, write after.
    @(negedge clk);
    rv[0] = 1'b1; ra[0] = 8'h10; wv[0] = 1'b1; wa[0] = 8'h20; wd[0] = 8'h3C;
    @(posedge clk);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      chk("sim_rd_rdy", 32'(rr[0]), 32'(k == 2));
      chk("sim_wr_quiet", 32'(wr[0]), 32'd0);
    end
    chk("sim_rd_data", 32'(rdat[0]), 32'hA5);
    last_rd[0] = 8'hA5;
    @(negedge clk);
    rv[0] = 1'b0;
    @(posedge clk); #1;
    chk("sim_rd_drop", 32'(rr[0]), 32'd0);
    chk("sim_idle_busy", 32'(bz[0]), 32'd0);
    chk("sim_wr_not_yet", 32'(wr[0]), 32'd0);
    @(posedge clk);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      chk("sim_wr_rdy", 32'(wr[0]), 32'(k == 2));
      chk("sim_rd_quiet", 32'(rr[0]), 32'd0);
    end
    mdl[0][8'h20] = 8'h3C; known[0][8'h20] = 1'b1;
    @(negedge clk);
    wv[0] = 1'b0;
    @(posedge clk); #1;
    chk("sim_wr_drop", 32'(wr[0]), 32'd0);
    chk("sim_wr_busy", 32'(bz[0]), 32'd0);
    run_op(0, 1'b0, 8'h20, 8'h00, 0);

    // Abort at latency 3: write 0x30=0xFF dropped after one cycle must not land.
    run_op(1, 1'b1, 8'h30, 8'h5A, 0);
    run_op(1, 1'b1, 8'h30, 8'hFF, 1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_rdy", 32'(wr[1]), 32'd0);
    end
    run_op(1, 1'b0, 8'h30, 8'h00, 0);

    // Reset asserted during READ_WAIT clears outputs at once; storage survives.
    @(negedge clk);
    rv[0] = 1'b1; ra[0] = 8'h10;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_rdy", 32'(rr[0]), 32'd0);
    chk("midrst_rdata", 32'(rdat[0]), 32'd0);
    chk("midrst_busy", 32'(bz[0]), 32'd0);
    @(negedge clk);
    rv[0] = 1'b0;
    reset = 1'b1;
    for (int d = 0; d < 4; d++) last_rd[d] = '0;
    run_op(0, 1'b0, 8'h10, 8'h00, 0);

    // Latency sweep endpoints.
    run_op(2, 1'b1, 8'h05, 8'hC3, 0);
    run_op(2, 1'b0, 8'h05, 8'h00, 0);
    run_op(3, 1'b1, 8'hFE, 8'h81, 0);
    run_op(3, 1'b0, 8'hFE, 8'h00, 0);

    // Random traffic on every instance.
    for (int i = 0; i < 24; i++) begin
      for (int d = 0; d < 4; d++) begin
        a  = 8'($urandom_range(0, 15));
        w  = ($urandom_range(0, 1) == 1) || !known[d][a];
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat(d))) : 0;
        run_op(d, w, a, 8'($urandom), ab);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
